// File: rtl/nn_calc_sequencer.sv
// Fully-connected layer sequencer: streams pixel/weight reads, MACs, saturates, stores one result per neuron.
// Build option: define NN_SEQ_RELU_EN to clamp negative stored results to zero.
module nn_calc_sequencer #(
  parameter int N_INPUTS  = 784,
  parameter int N_OUTPUTS = 10,
  parameter int PIX_AW    = 11,
  parameter int WGT_AW    = 13,
  parameter int ACC_W     = 26
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_calc_i,
  input  logic              clear_i,
  output logic              pixel_rd_en_o,
  output logic [PIX_AW-1:0] pixel_rd_addr_o,
  input  logic [7:0]        pixel_rd_data_i,
  output logic              weight_rd_en_o,
  output logic [WGT_AW-1:0] weight_rd_addr_o,
  input  logic [7:0]        weight_rd_data_i,
  output logic              result_wr_en_o,
  output logic [3:0]        result_wr_addr_o,
  output logic [16:0]       result_wr_data_o,
  output logic              busy_o,
  output logic              done_calc_o,
  output logic              overflow_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [PIX_AW-1:0]       LAST_IN  = PIX_AW'(N_INPUTS - 1);
  localparam logic [3:0]              LAST_OUT = 4'(N_OUTPUTS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'(65535);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = -ACC_W'(65536);

  logic [2:0]              state_q, state_d;
  logic                    start_q;
  logic [PIX_AW-1:0]       in_idx_q, in_idx_d;
  logic [WGT_AW-1:0]       w_idx_q, w_idx_d;
  logic [3:0]              out_idx_q, out_idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    acc_en_q, acc_en_d;
  logic                    overflow_q, overflow_d;

  logic                    start_rise;
  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic                    sat_hi, sat_lo;
  logic [16:0]             sat_val;

  assign start_rise = start_calc_i & ~start_q;

  // Pixel is unsigned, so a zero MSB is prepended before the signed multiply.
  assign prod     = $signed({1'b0, pixel_rd_data_i}) * $signed(weight_rd_data_i);
  assign prod_ext = $signed({{(ACC_W-17){prod[16]}}, prod});

  assign sat_hi  = acc_q > SAT_MAX;
  assign sat_lo  = acc_q < SAT_MIN;
  assign sat_val = sat_hi ? 17'h0FFFF : (sat_lo ? 17'h10000 : acc_q[16:0]);

  always_comb begin
    state_d    = state_q;
    in_idx_d   = in_idx_q;
    w_idx_d    = w_idx_q;
    out_idx_d  = out_idx_q;
    acc_d      = acc_q;
    overflow_d = overflow_q;
    // Read data lands one cycle after each RUN cycle, so accumulation trails RUN by one.
    acc_en_d   = (state_q == S_RUN);
    if (acc_en_q) acc_d = acc_q + prod_ext;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          state_d    = S_CLR;
          overflow_d = 1'b0;
          w_idx_d    = '0;
          out_idx_d  = '0;
        end
      end
      S_CLR: begin
        acc_d    = '0;
        in_idx_d = '0;
        state_d  = S_RUN;
      end
      S_RUN: begin
        in_idx_d = in_idx_q + PIX_AW'(1);
        w_idx_d  = w_idx_q + WGT_AW'(1);
        if (in_idx_q == LAST_IN) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_STORE;
      S_STORE: begin
        if (sat_hi || sat_lo) overflow_d = 1'b1;
        if (out_idx_q == LAST_OUT) begin
          state_d = S_DONE;
        end else begin
          out_idx_d = out_idx_q + 4'd1;
          state_d   = S_CLR;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear_i) begin
      state_d    = S_IDLE;
      overflow_d = 1'b0;
      acc_en_d   = 1'b0;
      in_idx_d   = '0;
      w_idx_d    = '0;
      out_idx_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      in_idx_q   <= '0;
      w_idx_q    <= '0;
      out_idx_q  <= '0;
      acc_q      <= '0;
      acc_en_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_calc_i;
      in_idx_q   <= in_idx_d;
      w_idx_q    <= w_idx_d;
      out_idx_q  <= out_idx_d;
      acc_q      <= acc_d;
      acc_en_q   <= acc_en_d;
      overflow_q <= overflow_d;
    end
  end

  assign pixel_rd_en_o    = (state_q == S_RUN);
  assign weight_rd_en_o   = (state_q == S_RUN);
  assign pixel_rd_addr_o  = in_idx_q;
  assign weight_rd_addr_o = w_idx_q;
  assign result_wr_en_o   = (state_q == S_STORE);
  assign result_wr_addr_o = out_idx_q;

`ifdef NN_SEQ_RELU_EN
  assign result_wr_data_o = sat_val[16] ? 17'h0 : sat_val;
`else
  assign result_wr_data_o = sat_val;
`endif

  assign busy_o      = (state_q == S_CLR) || (state_q == S_RUN) ||
                       (state_q == S_DRAIN) || (state_q == S_STORE);
  assign done_calc_o = (state_q == S_DONE);
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_nn_calc_sequencer.sv
// Bench for nn_calc_sequencer with a small layer (4 inputs, 2 neurons) and a read/write scoreboard.
module tb_nn_calc_sequencer;
  localparam int N_IN  = 4;
  localparam int N_OUT = 2;

  logic        clk;
  logic        n_rst;
  logic        start_calc;
  logic        clear;
  logic        pe, we, wre;
  logic [10:0] paddr;
  logic [12:0] waddr;
  logic [7:0]  pdata, wdata;
  logic [3:0]  wraddr;
  logic [16:0] wrdata;
  logic        busy, done, ovf;

  nn_calc_sequencer #(.N_INPUTS(N_IN), .N_OUTPUTS(N_OUT)) dut (
    .clk(clk), .n_rst(n_rst), .start_calc_i(start_calc), .clear_i(clear),
    .pixel_rd_en_o(pe), .pixel_rd_addr_o(paddr), .pixel_rd_data_i(pdata),
    .weight_rd_en_o(we), .weight_rd_addr_o(waddr), .weight_rd_data_i(wdata),
    .result_wr_en_o(wre), .result_wr_addr_o(wraddr), .result_wr_data_o(wrdata),
    .busy_o(busy), .done_calc_o(done), .overflow_o(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] pix_mem [0:2047];
  logic [7:0] wgt_mem [0:8191];

  initial begin
    pdata = 8'h0;
    wdata = 8'h0;
  end
  always @(posedge clk) begin
    if (pe) pdata <= pix_mem[paddr];
    if (we) wdata <= wgt_mem[waddr];
  end

  typedef struct packed { logic [10:0] p; logic [12:0] w; } rd_t;
  typedef struct packed { logic [3:0] a; logic [16:0] d; } wr_t;
  rd_t rd_q[$];
  wr_t wr_q[$];
  rd_t mon_rd;
  wr_t mon_wr;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({pe, we, wre, busy, done, ovf, paddr, waddr, wraddr, wrdata});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden model: expected read sequence and saturated (optionally clamped) sums per neuron.
  task automatic push_run(output logic exp_ovf);
    int s;
    int v;
    logic signed [7:0] wv;
    exp_ovf = 1'b0;
    for (int n = 0; n < N_OUT; n++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++) begin
        rd_q.push_back('{p: 11'(i), w: 13'(n * N_IN + i)});
        wv = wgt_mem[n * N_IN + i];
        s += int'(pix_mem[i]) * int'(wv);
      end
      if (s > 65535) begin
        v = 65535; exp_ovf = 1'b1;
      end else if (s < -65536) begin
        v = -65536; exp_ovf = 1'b1;
      end else begin
        v = s;
      end
`ifdef NN_SEQ_RELU_EN
      if (v < 0) v = 0;
`endif
      wr_q.push_back('{a: 4'(n), d: 17'(v)});
    end
  endtask

  task automatic load(input logic [7:0] p0, input logic [7:0] w0, input logic [7:0] w1);
    for (int i = 0; i < N_IN; i++) begin
      pix_mem[i]        = p0 + 8'(i * ((p0 == 8'd1) ? 1 : 0));
      wgt_mem[i]        = w0;
      wgt_mem[N_IN + i] = w1;
    end
  endtask

  always @(negedge clk) begin
    if (pe || we) begin
      if (rd_q.size() == 0) begin
        chk("rd_unexpected", 64'({pe, we}), 64'h0);
      end else begin
        mon_rd = rd_q.pop_front();
        $display("[TB] read  pix_addr=%0d wgt_addr=%0d", paddr, waddr);
        chk("rd_en_pair", 64'({pe, we}), 64'h3);
        chk("pix_addr", 64'(paddr), 64'(mon_rd.p));
        chk("wgt_addr", 64'(waddr), 64'(mon_rd.w));
      end
    end
    if (wre) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 64'(wre), 64'h0);
      end else begin
        mon_wr = wr_q.pop_front();
        $display("[TB] write addr=%0d data=%0h", wraddr, wrdata);
        chk("wr_addr", 64'(wraddr), 64'(mon_wr.a));
        chk("wr_data", 64'(wrdata), 64'(mon_wr.d));
      end
    end
  end

  logic eo;

  initial begin
    n_rst = 1'b0;
    start_calc = 1'b0;
    clear = 1'b0;
    repeat (3) tick();
    chk("rst_hold", outs(), 64'h0);
    n_rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_quiet", outs(), 64'h0);
    end

    // Saturating run: neuron 0 overflows high, neuron 1 low.
    load(8'd255, 8'd127, 8'h80);
    push_run(eo);
    start_calc = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 1)  chk("sat_busy", 64'({busy, done}), 64'h2);
      if (c == 14) chk("sat_not_done", 64'({busy, done}), 64'h2);
    end
    chk("sat_done", 64'({busy, done, ovf}), 64'({1'b0, 1'b1, eo}));
    chk("sat_ovf_expected", 64'(eo), 64'h1);
    chk("sat_drained", 64'({rd_q.size(), wr_q.size()}), 64'h0);

    // Start held high after DONE must not retrigger.
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("hold_no_retrigger", 64'({busy, done, ovf}), 64'({1'b0, 1'b1, eo}));
    end

    // Fresh rise: known-answer run, with a start rise injected while busy.
    start_calc = 1'b0;
    tick();
    load(8'd1, 8'd1, 8'hFF);
    push_run(eo);
    start_calc = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (c == 1)  chk("restart_clears", 64'({busy, done, ovf}), 64'h4);
      if (c == 4)  start_calc = 1'b0;
      if (c == 7)  start_calc = 1'b1;
      if (c == 14) chk("kat_not_done", 64'({busy, done}), 64'h2);
    end
    chk("kat_done", 64'({busy, done, ovf}), 64'h2);
    chk("kat_drained", 64'({rd_q.size(), wr_q.size()}), 64'h0);

    // Clear during neuron 1 RUN.
    start_calc = 1'b0;
    tick();
    load(8'd255, 8'd127, 8'd127);
    push_run(eo);
    start_calc = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 8)  chk("ovf_before_clear", 64'(ovf), 64'h1);
      if (c == 10) clear = 1'b1;
      if (c == 11) begin
        clear = 1'b0;
        chk("clear_reads_left", 64'(rd_q.size()), 64'h2);
        rd_q.delete();
        wr_q.delete();
        chk("clear_idle", 64'({busy, done, ovf, pe, wre}), 64'h0);
      end
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("clear_quiet", 64'({busy, done, ovf}), 64'h0);
    end

    // Asynchronous reset mid-run.
    start_calc = 1'b0;
    tick();
    push_run(eo);
    start_calc = 1'b1;
    repeat (3) tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst", outs(), 64'h0);
    rd_q.delete();
    wr_q.delete();
    start_calc = 1'b0;
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", outs(), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
